// File: rtl/divider_core.sv
// Iterative signed restoring divider: one quotient bit per clock, sign fix-up at the end.
// Define DIVIDER_REMAINDER_EN to add the signed data_remainder output.
module divider_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIVIDER_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   div_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               zero_pend_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
`ifdef DIVIDER_REMAINDER_EN
    logic [WIDTH-1:0]   remainder_q;
`endif

    // Negation in WIDTH bits is exact as an unsigned magnitude, MIN_INT included.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_mag = data_operandA[WIDTH-1] ? (WIDTH'(0) - data_operandA) : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? (WIDTH'(0) - data_operandB) : data_operandB;

    // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_q};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            zero_pend_q <= 1'b0;
            result_q    <= '0;
            exc_q       <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
            remainder_q <= '0;
`endif
        end else if (ctrl_div) begin
            // A start pulse in any state aborts the current operation.
            sign_a_q <= data_operandA[WIDTH-1];
            sign_b_q <= data_operandB[WIDTH-1];
            quo_q    <= a_mag;
            div_q    <= b_mag;
            rem_q    <= '0;
            cnt_q    <= '0;
            if (data_operandB == '0) begin
                zero_pend_q <= 1'b1;
                state_q     <= StIdle;
            end else begin
                zero_pend_q <= 1'b0;
                state_q     <= StRun;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (zero_pend_q) begin
                        zero_pend_q <= 1'b0;
                        result_q    <= '0;
                        exc_q       <= 1'b1;
`ifdef DIVIDER_REMAINDER_EN
                        remainder_q <= '0;
`endif
                        state_q     <= StDone;
                    end
                end
                StRun: begin
                    if (trial[WIDTH]) begin
                        rem_q <= shifted[WIDTH-1:0];
                    end else begin
                        rem_q <= trial[WIDTH-1:0];
                    end
                    quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                    exc_q    <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
                    remainder_q <= sign_a_q ? -rem_q : rem_q;
`endif
                    state_q  <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q == StRun) || (state_q == StFix);
`ifdef DIVIDER_REMAINDER_EN
    assign data_remainder = remainder_q;
`endif

endmodule

// File: tb/tb_divider_core.sv
// Self-checking bench for divider_core: directed vector table, random ops vs a
// plain-arithmetic model, and abort / async-reset sequences.
module tb_divider_core;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_div;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;
`ifdef DIVIDER_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [W-1:0] last_q = '0;

    divider_core #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIVIDER_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         exc;
        string        name;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed truncating division in 64 bits, so MIN_INT / -1 wraps on truncation.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic exc);
        longint sa, sb;
        if (b == '0) begin
            q = '0; r = '0; exc = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
            exc = 1'b0;
        end
    endfunction

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        ctrl_div = 1'b1;
        opa = a;
        opb = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        opa = $urandom;
        opb = $urandom;
    endtask

    // Counts falling edges after the capture edge until data_resultRDY; 0 on timeout.
    task automatic wait_rdy(input bit dz, input string name, output int n);
        logic busy_bad;
        busy_bad = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (busy !== (!dz && i <= 33)) busy_bad = 1'b1;
            if (data_resultRDY === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({name, " busy"}, W'(busy_bad), W'(0));
    endtask

    task automatic finish_op(input logic [W-1:0] q, input logic [W-1:0] r, input logic exc,
                             input string name, input int n, input int exp_n);
        chk({name, " latency"}, W'(n), W'(exp_n));
        chk({name, " result"}, data_result, q);
        chk({name, " exception"}, W'(data_exception), W'(exc));
`ifdef DIVIDER_REMAINDER_EN
        chk({name, " remainder"}, data_remainder, r);
`else
        if (r !== r) $display("unreachable");
`endif
        @(negedge clock);
        chk({name, " rdy width"}, W'(data_resultRDY), W'(0));
        chk({name, " result hold"}, data_result, q);
        last_q = q;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic exc, input string name);
        int n;
        start(a, b);
        wait_rdy(exc, name, n);
        finish_op(q, r, exc, name, n, exc ? 2 : 34);
    endtask

    initial begin
        logic [W-1:0] a, b, q, r;
        logic         exc;
        int           n;
        logic         rdy_bad;

        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, "100/7"};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "-100/7"};
        vecs[2]  = '{32'd5,        32'd0,        32'd0,        32'd0,        1'b1, "5/0"};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, "min/-1"};
        vecs[4]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, "min/2"};
        vecs[5]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, "0/5"};
        vecs[6]  = '{32'd7,        32'd100,      32'd0,        32'd7,        1'b0, "7/100"};
        vecs[7]  = '{32'hFFFFFFF7, 32'hFFFFFFFD, 32'd3,        32'd0,        1'b0, "-9/-3"};
        vecs[8]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, "max/1"};
        vecs[9]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "-7/2"};
        vecs[10] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, "min/min"};
        vecs[11] = '{32'h80000000, 32'd0,        32'd0,        32'd0,        1'b1, "min/0"};

        reset = 1'b0;
        ctrl_div = 1'b0;
        opa = '0;
        opb = '0;
        #12;
        chk("reset result", data_result, '0);
        chk("reset exception", W'(data_exception), W'(0));
        chk("reset rdy", W'(data_resultRDY), W'(0));
        chk("reset busy", W'(busy), W'(0));
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].exc, vecs[i].name);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 200));
            case ($urandom_range(0, 4))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            model(a, b, q, r, exc);
            run_op(a, b, q, r, exc, "random");
        end

        // Abort: a new start at E10 replaces 100/7; only one pulse, 33 cycles after E10.
        rdy_bad = 1'b0;
        start(32'd100, 32'd7);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) rdy_bad = 1'b1;
            if (i == 5) chk("abort held result", data_result, last_q);
        end
        start(32'hFFFFFFF7, 32'hFFFFFFFD);
        chk("abort no early rdy", W'(rdy_bad), W'(0));
        wait_rdy(1'b0, "abort", n);
        finish_op(32'd3, 32'd0, 1'b0, "abort", n, 34);

        // Asynchronous reset in the middle of an operation.
        start(32'd100, 32'd7);
        repeat (15) @(posedge clock);
        #5;
        reset = 1'b0;
        #1;
        chk("midreset result", data_result, '0);
        chk("midreset busy", W'(busy), W'(0));
        chk("midreset rdy", W'(data_resultRDY), W'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, "post-reset 50/5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
